// File: rtl/onehot_decode_seq_if.sv
// Handshake and status bundle for onehot_decode_seq.
// in_valid/in_ready: an index transfers on a rising clk edge where both are high; the sender
// holds in_valid and in_idx stable until then, and in_ready never depends on in_valid.
interface onehot_decode_seq_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_W-1:0]      in_idx;
  logic [(2**IDX_W)-1:0] out_onehot;
  logic                  out_valid;
  logic                  busy;
  logic [CNT_W-1:0]      accept_cnt;
  logic [1:0]            dbg_state;

  modport slave (
    input  in_valid, in_idx,
    output in_ready, out_onehot, out_valid, busy, accept_cnt, dbg_state
  );

  modport master (
    output in_valid, in_idx,
    input  in_ready, out_onehot, out_valid, busy, accept_cnt, dbg_state
  );
endinterface

// File: rtl/onehot_decode_seq.sv
// Binary index -> one-hot pulse of PULSE_LEN cycles, followed by GAP_LEN forced idle cycles.
// The decoded vector and its valid flag are registered; in_ready is only high in IDLE.
module onehot_decode_seq #(
  parameter int IDX_W     = 2,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  onehot_decode_seq_if.slave bus
);
  localparam int OUT_W   = 2**IDX_W;
  localparam int LEN_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW      = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_onehot;
  logic             r_valid;
  logic [CNT_W-1:0] r_accept_cnt;
  logic             w_accept;

  // in_idx is only looked at on an accepting edge, so X on it while idle never reaches r_onehot.
  assign w_accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_onehot     <= '0;
      r_valid      <= 1'b0;
      r_accept_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_onehot     <= OUT_W'(1) << bus.in_idx;
            r_valid      <= 1'b1;
            r_cnt        <= PULSE_LOAD;
            r_accept_cnt <= r_accept_cnt + 1'b1;
            r_state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_onehot <= '0;
            r_valid  <= 1'b0;
            if (GAP_LEN > 0) begin
              r_cnt   <= GAP_LOAD;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_onehot <= '0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE) && !rst;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = r_valid;
  assign bus.busy       = r_valid || (r_state == S_GAP);
  assign bus.accept_cnt = r_accept_cnt;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_onehot_decode_seq.sv
// Three instances (default, PULSE_LEN=1/GAP_LEN=0, CNT_W=2) share one stimulus stream and are
// each compared every cycle against a timeline model built from accept edges.
module tb_onehot_decode_seq;
  logic       clk = 1'b0;
  logic       tb_rst = 1'b1;
  logic       tb_valid = 1'b0;
  logic [1:0] tb_idx = 2'b00;

  always #5 clk = ~clk;

  onehot_decode_seq_if #(.IDX_W(2), .CNT_W(8)) if_a ();
  onehot_decode_seq_if #(.IDX_W(2), .CNT_W(8)) if_b ();
  onehot_decode_seq_if #(.IDX_W(2), .CNT_W(2)) if_c ();

  assign if_a.in_valid = tb_valid;
  assign if_a.in_idx   = tb_idx;
  assign if_b.in_valid = tb_valid;
  assign if_b.in_idx   = tb_idx;
  assign if_c.in_valid = tb_valid;
  assign if_c.in_idx   = tb_idx;

  onehot_decode_seq #(.IDX_W(2), .PULSE_LEN(3), .GAP_LEN(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(tb_rst), .bus(if_a.slave));
  onehot_decode_seq #(.IDX_W(2), .PULSE_LEN(1), .GAP_LEN(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(tb_rst), .bus(if_b.slave));
  onehot_decode_seq #(.IDX_W(2), .PULSE_LEN(3), .GAP_LEN(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(tb_rst), .bus(if_c.slave));

  logic [3:0] w_oh   [3];
  logic       w_ov   [3];
  logic       w_rdy  [3];
  logic       w_busy [3];
  logic [7:0] w_ac   [3];

  assign w_oh[0] = if_a.out_onehot;  assign w_ov[0] = if_a.out_valid;
  assign w_oh[1] = if_b.out_onehot;  assign w_ov[1] = if_b.out_valid;
  assign w_oh[2] = if_c.out_onehot;  assign w_ov[2] = if_c.out_valid;
  assign w_rdy[0] = if_a.in_ready;   assign w_busy[0] = if_a.busy;
  assign w_rdy[1] = if_b.in_ready;   assign w_busy[1] = if_b.busy;
  assign w_rdy[2] = if_c.in_ready;   assign w_busy[2] = if_c.busy;
  assign w_ac[0] = if_a.accept_cnt;
  assign w_ac[1] = if_b.accept_cnt;
  assign w_ac[2] = {6'b0, if_c.accept_cnt};

  int m_pulse [3] = '{3, 1, 3};
  int m_gap   [3] = '{1, 0, 1};
  int m_cw    [3] = '{8, 8, 2};

  // Model state: accept edge, edge from which the block is free again, accepts, decoded index.
  int         m_acc_edge [3];
  bit         m_have     [3];
  int         m_free_at  [3];
  int         m_accepts  [3];
  logic [3:0] m_vec      [3];
  logic [7:0] exp_q [$];

  int edge_n = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d edge%0d observed=%0h expected=%0h", tag, d, edge_n, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] idx);
    logic       e_ov;
    logic [7:0] e_ac;
    tb_rst   = r;
    tb_valid = v;
    tb_idx   = v ? idx : 2'bxx;
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        m_have[d]    = 1'b0;
        m_free_at[d] = edge_n;
        m_accepts[d] = 0;
      end else if (v && (edge_n - 1 >= m_free_at[d])) begin
        m_acc_edge[d] = edge_n;
        m_have[d]     = 1'b1;
        m_vec[d]      = 4'(1 << idx);
        m_accepts[d]++;
        m_free_at[d]  = edge_n + m_pulse[d] + m_gap[d];
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      e_ov = m_have[d] && (edge_n - m_acc_edge[d] < m_pulse[d]);
      e_ac = 8'(m_accepts[d] % (1 << m_cw[d]));
      exp_q.push_back(e_ov ? {4'b0, m_vec[d]} : 8'h00);
      chk("out_onehot", d, {4'b0, w_oh[d]}, exp_q.pop_front());
      chk("out_valid",  d, {7'b0, w_ov[d]}, {7'b0, e_ov});
      chk("busy",       d, {7'b0, w_busy[d]}, {7'b0, (!r && edge_n < m_free_at[d])});
      chk("in_ready",   d, {7'b0, w_rdy[d]}, {7'b0, (!r && edge_n >= m_free_at[d])});
      chk("accept_cnt", d, w_ac[d], e_ac);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_have[d] = 1'b0; m_free_at[d] = 0; m_accepts[d] = 0; m_acc_edge[d] = 0; m_vec[d] = 4'b0;
    end
    // Reset with valid asserted: nothing is accepted.
    cycle(1'b1, 1'b1, 2'd0);
    cycle(1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 2'd0);
    // Decode every index.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'(i));
      repeat (4) cycle(1'b0, 1'b0, 2'd0);
    end
    // Valid held, index changed mid-pulse.
    repeat (2) cycle(1'b0, 1'b1, 2'd2);
    repeat (8) cycle(1'b0, 1'b1, 2'd1);
    repeat (5) cycle(1'b0, 1'b0, 2'd0);
    // Reset on the second DRIVE cycle.
    cycle(1'b0, 1'b1, 2'd3);
    cycle(1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 2'd0);
    cycle(1'b0, 1'b0, 2'd0);
    // Short-pulse stream 3 then 0.
    cycle(1'b0, 1'b1, 2'd3);
    repeat (2) cycle(1'b0, 1'b1, 2'd0);
    repeat (5) cycle(1'b0, 1'b0, 2'd0);
    // Randomized traffic; also drives the CNT_W=2 counter through many wraps.
    repeat (400) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
